io_mmio_ctrl: RTL

- Memory-mapped I/O controller for the 0x8xxx_xxxx address space of the pipelined RISC-V core.
- Turns CPU load/store requests from the execute stage into UART ready/valid handshakes.
- Buffers receive and transmit bytes in small FIFOs.
- Provides cycle and retired-instruction counters.
- Read data returns with one-cycle latency, matching the synchronous data memories, so the memory-access stage muxes it in without extra stalls.

---
 rtl/io_mmio_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/io_mmio_ctrl.sv
// MMIO controller for the 0x8xxx_xxxx space: UART rx/tx FIFOs, status, and optional counters.
// Define MMIO_COUNTERS_EN to build the CYCLES/INSTRET counters and the CNT_RST register.
module io_mmio_ctrl #(
  parameter int RX_DEPTH = 8,
  parameter int TX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req_addr,
  input  logic        req_re,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  input  logic        inst_retired,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);

  logic [RX_AW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [TX_AW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [7:0]     tx_mem [TX_DEPTH];
  logic           rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
  logic [31:0]    rdata_q, rdata_d;
  logic [31:0]    cycles_val, instret_val, rd_val;

  logic       hit, is_store;
  logic [7:0] off;
  logic       rx_empty, rx_full, tx_empty, tx_full;
  logic       rx_push, rx_pop, tx_push, tx_pop, tx_wr;
  logic       unused_bits;

  assign hit      = (req_addr[31:28] == 4'h8);
  assign off      = req_addr[7:0];
  assign is_store = |req_we;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[RX_AW] != rx_rd_q[RX_AW]) &&
                    (rx_wr_q[RX_AW-1:0] == rx_rd_q[RX_AW-1:0]);
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[TX_AW] != tx_rd_q[TX_AW]) &&
                    (tx_wr_q[TX_AW-1:0] == tx_rd_q[TX_AW-1:0]);

  assign uart_rx_ready = !rx_full;
  assign uart_tx_valid = !tx_empty;
  assign uart_tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rd_q[TX_AW-1:0]];
  assign rdata         = rdata_q;

  assign rx_push = uart_rx_valid && !rx_full;
  assign rx_pop  = hit && req_re && (off == 8'h04) && !rx_empty;
  assign tx_pop  = !tx_empty && uart_tx_ready;
  assign tx_wr   = hit && req_we[0] && (off == 8'h08);
  // A store into a full FIFO still lands when the transmitter drains a slot this cycle.
  assign tx_push = tx_wr && (!tx_full || tx_pop);

  always_comb begin
    rx_wr_d  = rx_wr_q + (RX_AW+1)'(rx_push);
    rx_rd_d  = rx_rd_q + (RX_AW+1)'(rx_pop);
    tx_wr_d  = tx_wr_q + (TX_AW+1)'(tx_push);
    tx_rd_d  = tx_rd_q + (TX_AW+1)'(tx_pop);
    rx_ovf_d = rx_ovf_q;
    tx_ovf_d = tx_ovf_q;
    if (hit && is_store && (off == 8'h00)) begin
      rx_ovf_d = 1'b0;
      tx_ovf_d = 1'b0;
    end
    if (uart_rx_valid && rx_full) rx_ovf_d = 1'b1;
    if (tx_wr && tx_full && !tx_pop) tx_ovf_d = 1'b1;
  end

  always_comb begin
    rd_val = 32'h0;
    case (off)
      8'h00:   rd_val = {28'h0, rx_ovf_q, tx_ovf_q, !rx_empty, !tx_full};
      8'h04:   rd_val = {24'h0, rx_empty ? 8'h00 : rx_mem[rx_rd_q[RX_AW-1:0]]};
      8'h10:   rd_val = cycles_val;
      8'h14:   rd_val = instret_val;
      default: rd_val = 32'h0;
    endcase
    rdata_d = (hit && req_re) ? rd_val : rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      rx_ovf_q <= 1'b0;
      tx_ovf_q <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      rx_ovf_q <= rx_ovf_d;
      tx_ovf_q <= tx_ovf_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q[RX_AW-1:0]] <= uart_rx_data;
    if (tx_push) tx_mem[tx_wr_q[TX_AW-1:0]] <= req_wdata[7:0];
  end

`ifdef MMIO_COUNTERS_EN
  logic [31:0] cycles_q, cycles_d, instret_q, instret_d;
  logic        cnt_clr;

  // A clear store overrides the increment made in the same cycle.
  assign cnt_clr = hit && is_store && (off == 8'h18);

  always_comb begin
    cycles_d  = cnt_clr ? 32'h0 : cycles_q + 32'd1;
    instret_d = cnt_clr ? 32'h0 : instret_q + {31'h0, inst_retired};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles_q  <= 32'h0;
      instret_q <= 32'h0;
    end else begin
      cycles_q  <= cycles_d;
      instret_q <= instret_d;
    end
  end

  assign cycles_val  = cycles_q;
  assign instret_val = instret_q;
  assign unused_bits = ^{req_addr[27:8], req_wdata[31:8]};
`else
  assign cycles_val  = 32'h0;
  assign instret_val = 32'h0;
  assign unused_bits = ^{req_addr[27:8], req_wdata[31:8], inst_retired};
`endif

endmodule
